// File: rtl/vga_text_pkg.sv
// Shared constants and types for the VGA text path: screen geometry, control codes,
// sweep FSM states and the cursor operation encoding used by text_addr_gen.
package vga_text_pkg;

  localparam int COLS    = 80;
  localparam int ROWS    = 30;
  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 16;

  localparam logic [7:0] CHR_BS    = 8'h08;
  localparam logic [7:0] CHR_LF    = 8'h0A;
  localparam logic [7:0] CHR_FF    = 8'h0C;
  localparam logic [7:0] CHR_CR    = 8'h0D;
  localparam logic [7:0] FILL_CHAR = 8'h20;

  typedef enum logic {
    IDLE,
    CLEAR
  } text_state_t;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_ADVANCE,
    OP_NEWLINE,
    OP_RETURN,
    OP_BACK,
    OP_HOME
  } cursor_op_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/text_cursor_ctrl_if.sv
// Byte-in / character-RAM-write-out bus of text_cursor_ctrl.
// The master side supplies received bytes and observes the RAM write port.
interface text_cursor_ctrl_if #(
  parameter int ADDR_W = 12
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (
    output byte_valid, byte_data,
    input  wr_en, wr_addr, wr_data
  );

  modport slave (
    input  byte_valid, byte_data,
    output wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/text_addr_gen.sv
// Cursor column/row registers plus a running row_base (row*COLS) so the
// character address is a single add, never a multiply.
module text_addr_gen #(
  parameter int COLS   = vga_text_pkg::COLS,
  parameter int ROWS   = vga_text_pkg::ROWS,
  parameter int ADDR_W = 12,
  parameter int COL_W  = $clog2(COLS),
  parameter int ROW_W  = $clog2(ROWS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  vga_text_pkg::cursor_op_t op,
  output logic [COL_W-1:0]         col,
  output logic [ROW_W-1:0]         row,
  output logic [ADDR_W-1:0]        cur_addr,
  output logic [ADDR_W-1:0]        back_addr
);
  import vga_text_pkg::*;

  localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(COLS);

  logic [ADDR_W-1:0] row_base;
  logic [ROW_W-1:0]  row_inc;
  logic [ADDR_W-1:0] base_inc;

  // No scrolling: stepping past the last row lands back on row 0.
  always_comb begin
    row_inc  = row + ROW_W'(1);
    base_inc = row_base + ROW_STRIDE;
    if (row == LAST_ROW) begin
      row_inc  = '0;
      base_inc = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else begin
      case (op)
        OP_ADVANCE: begin
          if (col == LAST_COL) begin
            col      <= '0;
            row      <= row_inc;
            row_base <= base_inc;
          end else begin
            col <= col + COL_W'(1);
          end
        end
        OP_NEWLINE: begin
          row      <= row_inc;
          row_base <= base_inc;
        end
        OP_RETURN: col <= '0;
        OP_BACK: begin
          if (col != '0) col <= col - COL_W'(1);
        end
        OP_HOME: begin
          col      <= '0;
          row      <= '0;
          row_base <= '0;
        end
        default: ;
      endcase
    end
  end

  assign cur_addr  = row_base + ADDR_W'(col);
  assign back_addr = row_base + ADDR_W'(col - COL_W'(1));

endmodule

// File: rtl/text_cursor_ctrl.sv
// Turns received SPI bytes into character-RAM writes and cursor moves (CR/LF/BS/FF).
// Define TEXT_CURSOR_CLEAR_ON_RESET_EN to sweep the screen blank after every reset.
module text_cursor_ctrl #(
  parameter int         COLS      = vga_text_pkg::COLS,
  parameter int         ROWS      = vga_text_pkg::ROWS,
  parameter int         ADDR_W    = 12,
  parameter logic [7:0] FILL_CHAR = vga_text_pkg::FILL_CHAR,
  parameter int         COL_W     = $clog2(COLS),
  parameter int         ROW_W     = $clog2(ROWS)
) (
  input  logic               clk,
  input  logic               rst,
  text_cursor_ctrl_if.slave  bus,
  output logic [COL_W-1:0]   cursor_col,
  output logic [ROW_W-1:0]   cursor_row,
  output logic               busy,
  output logic               dropped
);
  import vga_text_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);

  text_state_t       state, state_nxt;
  cursor_op_t        op;
  logic              wr_en_q, wr_en_nxt;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_nxt;
  logic [7:0]        wr_data_q, wr_data_nxt;
  logic              busy_nxt, dropped_nxt;
  logic              start_sweep;
  logic              init_pending;
  logic [ADDR_W-1:0] cur_addr, back_addr;

  text_addr_gen #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W),
    .COL_W  (COL_W),
    .ROW_W  (ROW_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .op        (op),
    .col       (cursor_col),
    .row       (cursor_row),
    .cur_addr  (cur_addr),
    .back_addr (back_addr)
  );

`ifdef TEXT_CURSOR_CLEAR_ON_RESET_EN
  // High for exactly the first cycle after reset releases, which kicks off a sweep.
  always_ff @(posedge clk) init_pending <= rst;
`else
  assign init_pending = 1'b0;
`endif

  // The sweep reuses the wr_addr register as its counter; wr_addr==LAST_ADDR in CLEAR
  // means the final fill write is on the bus this cycle.
  always_comb begin
    state_nxt   = state;
    op          = OP_NONE;
    wr_en_nxt   = 1'b0;
    wr_addr_nxt = wr_addr_q;
    wr_data_nxt = wr_data_q;
    busy_nxt    = busy;
    dropped_nxt = dropped;
    start_sweep = 1'b0;

    case (state)
      IDLE: begin
        if (init_pending) begin
          start_sweep = 1'b1;
          dropped_nxt = dropped | bus.byte_valid;
        end else if (bus.byte_valid) begin
          if (is_printable(bus.byte_data)) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = cur_addr;
            wr_data_nxt = bus.byte_data;
            op          = OP_ADVANCE;
          end else begin
            case (bus.byte_data)
              CHR_CR: op = OP_RETURN;
              CHR_LF: op = OP_NEWLINE;
              CHR_BS: begin
                if (cursor_col != '0) begin
                  wr_en_nxt   = 1'b1;
                  wr_addr_nxt = back_addr;
                  wr_data_nxt = FILL_CHAR;
                  op          = OP_BACK;
                end
              end
              CHR_FF:  start_sweep = 1'b1;
              default: ;
            endcase
          end
        end
      end
      CLEAR: begin
        if (bus.byte_valid) dropped_nxt = 1'b1;
        if (wr_addr_q == LAST_ADDR) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          op        = OP_HOME;
        end else begin
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = wr_addr_q + ADDR_W'(1);
          wr_data_nxt = FILL_CHAR;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (start_sweep) begin
      state_nxt   = CLEAR;
      busy_nxt    = 1'b1;
      wr_en_nxt   = 1'b1;
      wr_addr_nxt = '0;
      wr_data_nxt = FILL_CHAR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy      <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      state     <= state_nxt;
      wr_en_q   <= wr_en_nxt;
      wr_addr_q <= wr_addr_nxt;
      wr_data_q <= wr_data_nxt;
      busy      <= busy_nxt;
      dropped   <= dropped_nxt;
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// Scoreboard bench for text_cursor_ctrl: expected RAM writes are queued as bytes are
// driven and matched against the write port; the cursor is tracked by a small model.
module tb_text_cursor_ctrl;

  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int ADDR_W = 12;
  localparam int SCREEN = COLS * ROWS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;
  logic       busy;
  logic       dropped;

  int          assertions = 0;
  int          failures   = 0;
  int          mcol       = 0;
  int          mrow       = 0;
  logic [19:0] exp_q[$];
  logic [19:0] mon_exp;

  text_cursor_ctrl_if #(.ADDR_W(ADDR_W)) bus();

  text_cursor_ctrl #(
    .COLS      (COLS),
    .ROWS      (ROWS),
    .ADDR_W    (ADDR_W),
    .FILL_CHAR (8'h20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy),
    .dropped    (dropped)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic pushWrite(input int addr, input logic [7:0] data);
    logic [31:0] a;
    a = addr;
    exp_q.push_back({a[11:0], data});
  endtask

  // Every RAM write seen on the bus must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_write", {12'h0, bus.wr_addr, bus.wr_data}, 32'hFFFF_FFFF);
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("wr_addr", 32'(bus.wr_addr), 32'(mon_exp[19:8]));
        checkOutput("wr_data", 32'(bus.wr_data), 32'(mon_exp[7:0]));
      end
    end
  end

  task automatic waitSweep(input bit inject);
    int cycles = 0;
    while (busy === 1'b1 && cycles < 3000) begin
      cycles++;
      if (inject && cycles == 500) begin
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h41;
      end
      @(posedge clk);
      #1;
      bus.byte_valid = 1'b0;
    end
    checkOutput("sweep_busy_cycles", 32'(cycles), 32'(SCREEN));
    checkOutput("busy_after_sweep", 32'(busy), 32'd0);
  endtask

  task automatic doReset();
    rst            = 1'b1;
    bus.byte_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_wr_en", 32'(bus.wr_en), 32'd0);
    checkOutput("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    checkOutput("rst_wr_data", 32'(bus.wr_data), 32'd0);
    checkOutput("rst_cursor_col", 32'(cursor_col), 32'd0);
    checkOutput("rst_cursor_row", 32'(cursor_row), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_dropped", 32'(dropped), 32'd0);
    rst  = 1'b0;
    mcol = 0;
    mrow = 0;
    @(posedge clk);
    #1;
`ifdef TEXT_CURSOR_CLEAR_ON_RESET_EN
    for (int a = 0; a < SCREEN; a++) pushWrite(a, 8'h20);
    waitSweep(1'b0);
`endif
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      pushWrite(mrow * COLS + mcol, b);
      mcol++;
      if (mcol == COLS) begin
        mcol = 0;
        mrow = (mrow + 1) % ROWS;
      end
    end else if (b == 8'h0D) begin
      mcol = 0;
    end else if (b == 8'h0A) begin
      mrow = (mrow + 1) % ROWS;
    end else if (b == 8'h08) begin
      if (mcol > 0) begin
        mcol--;
        pushWrite(mrow * COLS + mcol, 8'h20);
      end
    end else if (b == 8'h0C) begin
      for (int a = 0; a < SCREEN; a++) pushWrite(a, 8'h20);
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
    if (b == 8'h0C) begin
      waitSweep(1'b1);
      mcol = 0;
      mrow = 0;
    end
    checkOutput("cursor_col", 32'(cursor_col), 32'(mcol));
    checkOutput("cursor_row", 32'(cursor_row), 32'(mrow));
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] ignored[6];
    ignored = '{8'h00, 8'h1F, 8'h7F, 8'h80, 8'hFF, 8'h1B};
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;

    doReset();
    applyStimulus(8'h41);

    // Fill row 0 exactly, then the next byte lands at the start of row 1.
    applyStimulus(8'h0D);
    for (int i = 0; i < COLS; i++) applyStimulus(8'(8'h30 + i % 10));
    applyStimulus(8'h42);

    while (mrow != ROWS - 1) applyStimulus(8'h0A);
    applyStimulus(8'h0D);
    repeat (5) applyStimulus(8'h61);
    applyStimulus(8'h0A);

    while (mrow != ROWS - 1) applyStimulus(8'h0A);
    applyStimulus(8'h0D);
    repeat (COLS - 1) applyStimulus(8'h7E);
    applyStimulus(8'h41);

    foreach (ignored[i]) applyStimulus(ignored[i]);

    applyStimulus(8'h0A);
    applyStimulus(8'h0A);
    repeat (3) applyStimulus(8'h20);
    applyStimulus(8'h08);
    applyStimulus(8'h0D);
    applyStimulus(8'h08);

    applyStimulus(8'h0C);
    checkOutput("dropped_set", 32'(dropped), 32'd1);

    // Abort a sweep with reset after 100 fill writes.
    applyStimulus(8'h41);
    applyStimulus(8'h42);
    for (int a = 0; a < 100; a++) pushWrite(a, 8'h20);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h0C;
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
    repeat (99) begin
      @(posedge clk);
      #1;
    end
    doReset();

    repeat (5) begin
      @(posedge clk);
      #1;
    end
    applyStimulus(8'h5A);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("pending_writes", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
